// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment receive monitor: segment patterns
// in A..G order (MSB = A), the blank pattern and the blink FSM state type.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Entry i holds the pattern for hex value i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_DARK = 2'd2
    } blink_state_t;

endpackage

// File: rtl/seven_segment_reader_decode.sv
// Combinational reverse lookup of a segment pattern to its hex nibble.
// Patterns outside the table report o_legal=0 with a zero nibble.
module seg7_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_legal  = 1'b0;
        o_nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_TABLE[i]) begin
                o_legal  = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Receive-side monitor for a seven-segment driver: glitch-filters the lines,
// decodes committed frames back to hex and measures the blink period.
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int unsigned         STABLE_CYC = 4,
    parameter int unsigned         PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] TIMEOUT    = PERIOD_W'(24'hFFFFFF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic                dp_in,
    input  logic                en_in,
    output logic [3:0]          digit,
    output logic                dp_out,
    output logic                digit_valid,
    output logic                illegal,
    output logic                blinking,
    output logic [PERIOD_W-1:0] blink_period,
    output logic                period_valid
);

    localparam logic [7:0]          CNT_MAX = 8'(STABLE_CYC);
    localparam logic [7:0]          CNT_HIT = 8'(STABLE_CYC - 1);
    localparam logic [PERIOD_W-1:0] TO_M1   = TIMEOUT - PERIOD_W'(1);

    // Frame layout: {en, dp, seg[6:0]}
    logic [8:0]          r_s;
    logic [8:0]          r_p;
    logic [7:0]          r_cnt;
    logic [7:0]          r_last_vis;
    logic                r_vis_seen;
    blink_state_t        r_state;
    logic [PERIOD_W-1:0] r_pcnt;
    logic                r_edge_seen;

    logic       w_same;
    logic       w_commit;
    logic       w_blank;
    logic       w_vis_commit;
    logic       w_rise;
    logic       w_legal;
    logic [3:0] w_nibble;

    seg7_pattern_decode u_decode (
        .i_seg    (r_s[6:0]),
        .o_legal  (w_legal),
        .o_nibble (w_nibble)
    );

    assign w_same       = (r_s == r_p);
    // Fires only on the CNT_HIT -> CNT_MAX step, so once per stable interval.
    assign w_commit     = w_same && (r_cnt == CNT_HIT);
    assign w_blank      = !r_s[8] || (r_s[6:0] == SEG_BLANK);
    assign w_vis_commit = w_commit && !w_blank;
    assign w_rise       = w_vis_commit && (r_state == ST_DARK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else begin
            r_s <= {en_in, dp_in, seg_in};
            r_p <= r_s;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit       <= '0;
            dp_out      <= 1'b0;
            illegal     <= 1'b0;
            digit_valid <= 1'b0;
            r_last_vis  <= '0;
            r_vis_seen  <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            if (w_vis_commit) begin
                digit       <= w_legal ? w_nibble : 4'd0;
                dp_out      <= r_s[7];
                illegal     <= !w_legal;
                // A frame that reappears unchanged after a blink is not news.
                digit_valid <= !r_vis_seen || (r_s[7:0] != r_last_vis);
                r_last_vis  <= r_s[7:0];
                r_vis_seen  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pcnt       <= '0;
            r_edge_seen  <= 1'b0;
            blinking     <= 1'b0;
            blink_period <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            // Every commit lands in SHOW or DARK by its class, whatever the source state.
            if (w_commit)
                r_state <= w_blank ? ST_DARK : ST_SHOW;

            if (w_rise) begin
                if (r_edge_seen) begin
                    blink_period <= r_pcnt + PERIOD_W'(1);
                    period_valid <= 1'b1;
                    blinking     <= 1'b1;
                end
                r_edge_seen <= 1'b1;
                r_pcnt      <= '0;
            end else begin
                if (r_pcnt != TIMEOUT)
                    r_pcnt <= r_pcnt + PERIOD_W'(1);
                if (r_pcnt >= TO_M1) begin
                    blinking    <= 1'b0;
                    r_edge_seen <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side monitor for the seven-segment driver interface.
- Samples the `seg`/`dp`/`en` lines the display driver produces and filters glitches with a stability counter.
- Decodes committed patterns back to a hex nibble and measures the blink period.
- Used as a checker/loopback block beside the display driver in benches and in self-test builds.

Parameters:
- STABLE_CYC, 4: number of consecutive identical samples required before a frame is committed; legal range 2..255.
- PERIOD_W, 24: width of the blink period counter and output; matches the driver's blink_rate width.
- TIMEOUT, 24'hFFFFFF: cycles without a blank-to-visible commit after which blinking is declared stopped; must be at most 2^PERIOD_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- seg_in  input  7  segment lines, MSB = A, LSB = G; 1 = lit.
- dp_in  input  1  decimal point line; 1 = lit.
- en_in  input  1  display enable; 0 = display dark.
- digit  output  4  last committed decoded hex value.
- dp_out  output  1  dp of last committed visible frame.
- digit_valid  output  1  one-cycle pulse when a new visible frame commits.
- illegal  output  1  last committed visible pattern is not in the hex table.
- blinking  output  1  a periodic blank/visible alternation is in progress.
- blink_period  output  PERIOD_W  last measured period, in clk cycles.
- period_valid  output  1  one-cycle pulse when blink_period updates.

Behaviour:
- Reset (rst=0, async): every output goes to 0. Internal state also clears: sample registers, stability counter, period counter, edge_seen, last-visible register, and the FSM (to IDLE).
- Sampling:
  - frame = {en_in, dp_in, seg_in}, registered every edge into s; the previous value of s is held in p.
  - If s == p, cnt increments and saturates at STABLE_CYC. Otherwise cnt clears to 0.
  - A commit fires on the single cycle where cnt goes from STABLE_CYC-1 to STABLE_CYC. Commit happens exactly once per stable interval.
  - Latency: if the inputs change before edge k and then hold, outputs update after edge k+STABLE_CYC+1.
- Commit classification:
  - BLANK: en=0 or seg==0.
  - VISIBLE: otherwise.
- VISIBLE commit:
  - digit <= table lookup.
  - dp_out <= dp.
  - illegal <= pattern not in the table; on an illegal pattern digit <= 0.
  - digit_valid pulses only if {dp,seg} differs from the last committed visible frame, or if this is the first visible commit since reset. Reappearance after a blink does not pulse.
- BLANK commit: digit, dp_out and illegal hold their values.
- Hex table (A..G):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Blink FSM:
  - States: IDLE, SHOW, DARK.
  - IDLE -> SHOW on a VISIBLE commit; IDLE -> DARK on a BLANK commit.
  - SHOW -> DARK on a BLANK commit.
  - DARK -> SHOW on a VISIBLE commit; this is a rise event.
  - pcnt increments every cycle and saturates at TIMEOUT.
- Rise event:
  - If edge_seen=1: blink_period <= pcnt+1 (cycles between commits), period_valid pulses, blinking <= 1.
  - In all cases: edge_seen <= 1 and pcnt <= 0.
- Timeout: when pcnt reaches TIMEOUT, blinking <= 0 and edge_seen <= 0. The FSM state and blink_period are kept.
- Simultaneous events: a rise event in the same cycle pcnt hits TIMEOUT counts as a rise; the timeout is ignored.
- Mid-operation reset: the next frame needs the full STABLE_CYC qualification. The first visible commit after reset pulses digit_valid.

Decomposition:
- Package seven_segment_pkg:
  - 16 segment pattern constants (A..G order).
  - SEG_BLANK constant.
  - FSM state typedef (IDLE/SHOW/DARK).
- Sub-module seg7_pattern_decode: combinational 7-bit -> {legal, nibble} lookup, instantiated once.

Test Plan:
- Reset mid-stream: assert rst=0 while blinking=1 -> all outputs 0 immediately; after release, a stable "3" (1111001) yields digit=3 with digit_valid after 6 edges (STABLE_CYC=4).
- Glitch filter: seg toggles 1111110/0110000 every 3 cycles, then holds 0110000 -> no commit during toggling; one digit_valid with digit=1.
- Illegal and dp: hold seg=1010101, dp=1 -> illegal=1, digit=0, dp_out=1; then hold seg=1000111 -> digit=F, illegal=0.
- Blink measure: en_in 100 cycles high / 100 cycles low around "8" -> period_valid on the second rise with blink_period=200, blinking=1; digit_valid fires once only.
- Timeout: TIMEOUT=50, blinking established, then en_in held high -> blinking drops 50 cycles after the last rise; blink_period holds 200.
- Blank via seg: en_in=1, seg=0000000 between digits -> treated as BLANK; the FSM enters DARK.
